// File: rtl/mem_pkg.sv
// Shared definitions for the RV64 data memory: funct3 codes, FSM encoding,
// opcodes and access-size helpers.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Byte-lane mask of an access at offset 0; funct3[1:0] encodes log2(size).
  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    logic [7:0] m;
    case (sz)
      2'd0:    m = 8'h01;
      2'd1:    m = 8'h03;
      2'd2:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  // Low offset bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] align_mask(input logic [1:0] sz);
    logic [2:0] m;
    case (sz)
      2'd0:    m = 3'b000;
      2'd1:    m = 3'b001;
      2'd2:    m = 3'b011;
      default: m = 3'b111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_load_extend.sv
// Aligns the addressed bytes of a memory word to bit 0 and sign/zero-extends
// them according to the RV64I load funct3.
module mem_load_extend
  import mem_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] word,
  input  logic [2:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] shifted;

  assign shifted = word >> {offset, 3'b000};

  always_comb begin
    result = '0;
    case (funct3)
      F3_B:  result = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
      F3_H:  result = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      F3_W:  result = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      F3_D:  result = shifted;
      F3_BU: result = {{(XLEN-8){1'b0}},  shifted[7:0]};
      F3_HU: result = {{(XLEN-16){1'b0}}, shifted[15:0]};
      F3_WU: result = {{(XLEN-32){1'b0}}, shifted[31:0]};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Byte-addressed RV64 data memory with valid/ready handshake and fixed access
// latency; memory is written and read at the acceptance edge.
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int DEPTH   = 32,
  parameter int LATENCY = 2,
  parameter int ADDR_W  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err
);

  localparam int NUM_LANES = XLEN / 8;
  localparam int IDX_W     = $clog2(DEPTH);
  localparam int CNT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(DEPTH * 8);
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);

  if (XLEN != 64) begin : g_bad_xlen
    $error("data_mem_ctrl: only XLEN=64 is supported");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("data_mem_ctrl: DEPTH must be a power of 2 and >= 2");
  end
  if (LATENCY < 1) begin : g_bad_latency
    $error("data_mem_ctrl: LATENCY must be >= 1");
  end

  state_t                           state, state_nxt;
  logic [CNT_W-1:0]                 lat_cnt;
  logic [XLEN-1:0]                  mem [DEPTH];

  logic                             accept;
  logic [IDX_W-1:0]                 word_idx;
  logic [2:0]                       byte_off;
  logic                             misaligned, out_of_range, illegal_f3, acc_err;
  logic                             do_write;
  logic [NUM_LANES-1:0]             byte_mask;
  logic [XLEN-1:0]                  wdata_sh;
  logic [NUM_LANES-1:0]             lane_we;
  logic [NUM_LANES-1:0][7:0]        lane_wd;
  logic [XLEN-1:0]                  rd_word, ld_data;

  assign accept   = (state == ST_IDLE) && req_valid;
  assign word_idx = req_addr[IDX_W+2:3];
  assign byte_off = req_addr[2:0];

  // Error check: all three causes suppress the write and zero the read data.
  assign misaligned   = |(byte_off & align_mask(req_funct3[1:0]));
  assign out_of_range = req_addr >= ADDR_LIMIT;
  assign illegal_f3   = req_we ? req_funct3[2] : (req_funct3 == 3'b111);
  assign acc_err      = misaligned | out_of_range | illegal_f3;
  assign do_write     = accept & req_we & ~acc_err;

  // Aligned accesses never spill past lane 7, so the shift cannot overflow.
  assign byte_mask = size_mask(req_funct3[1:0]) << byte_off;
  assign wdata_sh  = req_wdata << {byte_off, 3'b000};

  for (genvar b = 0; b < NUM_LANES; b++) begin : g_lane
    assign lane_we[b] = do_write & byte_mask[b];
    assign lane_wd[b] = wdata_sh[b*8 +: 8];
  end

  // Storage is not reset; only the addressed byte lanes are updated.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_LANES; b++) begin
      if (lane_we[b]) mem[word_idx][b*8 +: 8] <= lane_wd[b];
    end
  end

  assign rd_word = mem[word_idx];

  mem_load_extend #(.XLEN(XLEN)) u_load_extend (
    .word   (rd_word),
    .offset (byte_off),
    .funct3 (req_funct3),
    .result (ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (req_valid) state_nxt = (LATENCY > 1) ? ST_WAIT : ST_RESP;
      ST_WAIT: if (lat_cnt == CNT_LAST) state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == ST_IDLE);
    rsp_valid = (state == ST_RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   lat_cnt <= '0;
    else if (accept)              lat_cnt <= '0;
    else if (state == ST_WAIT)    lat_cnt <= lat_cnt + 1'b1;
  end

  // Response is captured at acceptance and held until the RESP->IDLE edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      rsp_rdata <= (req_we || acc_err) ? '0 : ld_data;
      rsp_err   <= acc_err;
    end else if (state == ST_RESP && rsp_ready) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomized self-checking bench for data_mem_ctrl against a byte-array
// reference model of the RV64 load/store rules.
module tb_data_mem_ctrl;

  localparam int XLEN    = 64;
  localparam int DEPTH   = 32;
  localparam int LATENCY = 2;
  localparam int ADDR_W  = 64;
  localparam int NBYTES  = DEPTH * 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid, req_ready, req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              rsp_valid, rsp_ready, rsp_err;
  logic [XLEN-1:0]   rsp_rdata;

  int vectors = 0;
  int errs    = 0;

  logic [7:0]  mmem [NBYTES];
  logic [63:0] exp_rd;
  logic        exp_err;

  always #5 clk = ~clk;

  data_mem_ctrl #(.XLEN(XLEN), .DEPTH(DEPTH), .LATENCY(LATENCY), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: byte-addressed little-endian memory, RV64I size/sign rules.
  task automatic model_req(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                           input logic [63:0] wd, output logic [63:0] rd, output logic err);
    int sz;
    logic [63:0] v;
    sz  = 1 << f3[1:0];
    err = (addr >= 64'(NBYTES)) || ((addr % 64'(sz)) != 0) || (we ? (f3 >= 3'd4) : (f3 == 3'd7));
    rd  = '0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < sz; i++) mmem[int'(addr) + i] = wd[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < sz; i++) v = v | (64'(mmem[int'(addr) + i]) << (8*i));
        if (f3 < 3'd4 && sz < 8 && v[8*sz-1]) v = v | (~64'd0 << (8*sz));
        rd = v;
      end
    end
  endtask

  task automatic send(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                      input logic [63:0] wd);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("accept_timeout", 64'(req_ready), 64'd1);
    model_req(we, f3, addr, wd, exp_rd, exp_err);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic get_rsp(input int hold, input logic use_k, input logic [63:0] k_rd,
                         input logic k_err);
    int n;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (rsp_valid) break;
    end
    chk("latency", 64'(n), 64'(LATENCY));
    chk("rdata", rsp_rdata, exp_rd);
    chk("err", 64'(rsp_err), 64'(exp_err));
    if (use_k) begin
      chk("rdata_const", rsp_rdata, k_rd);
      chk("err_const", 64'(rsp_err), 64'(k_err));
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(rsp_valid), 64'd1);
      chk("hold_rdata", rsp_rdata, exp_rd);
      chk("hold_ready", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    chk("rel_valid", 64'(rsp_valid), 64'd0);
    chk("rel_rdata", rsp_rdata, 64'd0);
    chk("rel_err", 64'(rsp_err), 64'd0);
    chk("rel_ready", 64'(req_ready), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a, d;
    logic [2:0]  f;
    logic        w;

    rst_n = 1'b0; rsp_ready = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rdata", rsp_rdata, 64'd0);
    chk("rst_err", 64'(rsp_err), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("rst_ready", 64'(req_ready), 64'd1);

    for (int i = 0; i < DEPTH; i++) begin
      send(1'b1, 3'd3, 64'(i*8), {$urandom, $urandom});
      get_rsp(0, 1'b0, '0, 1'b0);
    end

    // Full doubleword store / load and sub-word views of it.
    send(1'b1, 3'd3, 64'h10, 64'hFFFF_FFFF_FFFF_FF80); get_rsp(0, 1'b1, 64'd0, 1'b0);
    send(1'b0, 3'd3, 64'h10, 64'd0); get_rsp(0, 1'b1, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
    send(1'b0, 3'd0, 64'h10, 64'd0); get_rsp(0, 1'b1, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
    send(1'b0, 3'd4, 64'h10, 64'd0); get_rsp(0, 1'b1, 64'h80, 1'b0);
    send(1'b0, 3'd5, 64'h12, 64'd0); get_rsp(0, 1'b1, 64'hFFFF, 1'b0);
    send(1'b0, 3'd2, 64'h14, 64'd0); get_rsp(0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);

    // Byte merge into a zeroed word.
    send(1'b1, 3'd3, 64'h20, 64'd0);  get_rsp(0, 1'b0, '0, 1'b0);
    send(1'b1, 3'd0, 64'h23, 64'hAB); get_rsp(0, 1'b0, '0, 1'b0);
    send(1'b0, 3'd3, 64'h20, 64'd0);  get_rsp(0, 1'b1, 64'h0000_0000_AB00_0000, 1'b0);

    // Error cases; the rejected store must not touch any word.
    send(1'b0, 3'd2, 64'h22, 64'd0);  get_rsp(0, 1'b1, 64'd0, 1'b1);
    send(1'b1, 3'd3, 64'h100, 64'hDEAD_BEEF_DEAD_BEEF); get_rsp(0, 1'b1, 64'd0, 1'b1);
    send(1'b0, 3'd7, 64'h8, 64'd0);   get_rsp(0, 1'b1, 64'd0, 1'b1);
    send(1'b1, 3'd4, 64'h8, 64'd5);   get_rsp(0, 1'b1, 64'd0, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      send(1'b0, 3'd3, 64'(i*8), 64'd0);
      get_rsp(0, 1'b0, '0, 1'b0);
    end

    // Async reset in WAIT abandons a load; a store accepted before reset sticks.
    send(1'b0, 3'd3, 64'h10, 64'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(rsp_valid), 64'd0);
    chk("mid_rst_ready", 64'(req_ready), 64'd1);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_valid", 64'(rsp_valid), 64'd0);
    end
    send(1'b1, 3'd3, 64'h30, 64'h0123_4567_89AB_CDEF);
    @(negedge clk);
    rst_n = 1'b0;
    #3 rst_n = 1'b1;
    send(1'b0, 3'd3, 64'h30, 64'd0); get_rsp(0, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b0);

    // Backpressure with a second request held on the input.
    send(1'b0, 3'd6, 64'h34, 64'd0);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd1; req_addr = 64'h36; req_wdata = 64'h5A5A;
    get_rsp(5, 1'b1, 64'h0000_0000_0123_4567, 1'b0);
    send(1'b1, 3'd1, 64'h36, 64'h5A5A); get_rsp(0, 1'b0, '0, 1'b0);
    send(1'b0, 3'd3, 64'h30, 64'd0);    get_rsp(0, 1'b1, 64'h5A5A_4567_89AB_CDEF, 1'b0);

    // Random mix of sizes, signs, alignments and ranges.
    for (int k = 0; k < 250; k++) begin
      w = 1'($urandom_range(0, 1));
      f = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0:       a = 64'(NBYTES + $urandom_range(0, 300));
        1:       a = {$urandom, $urandom};
        2, 3:    a = 64'($urandom_range(0, DEPTH - 1) * 8) + 64'(8'h01 << f[1:0]) * 64'($urandom_range(0, 7)) % 8;
        default: a = 64'($urandom_range(0, NBYTES - 1));
      endcase
      d = {$urandom, $urandom};
      send(w, f, a, d);
      get_rsp($urandom_range(0, 2), 1'b0, '0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
